// File: rtl/snake_pixel_renderer.sv
// snake_pixel_renderer: turns VGA pixel coordinates into board RAM reads and
// RGB444 pixels for a 32x24 board of 20x20 cells. The sync signals and the
// visible-area flag travel alongside the 3-cycle read/colour pipeline, and a
// frame tick marks the start of vertical blanking for the game logic.
// Optional build macro: GRID_LINES_EN (draws grey cell borders on empty cells).
module snake_pixel_renderer #(
  parameter int          CELL_PX   = 20,
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 24,
  parameter logic [11:0] COL_EMPTY = 12'h000,
  parameter logic [11:0] COL_BODY  = 12'h0F0,
  parameter logic [11:0] COL_HEAD  = 12'hFF0,
  parameter logic [11:0] COL_FOOD  = 12'hF00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] rd_addr,
  output logic       rd_en,
  input  logic [1:0] rd_data,
  output logic [11:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick
);

  // Sub-cell offset width, board index widths and the counter width needed to
  // follow px/py through blanking (up to 1023/CELL_PX) without overflow.
  localparam int SUB_W = $clog2(CELL_PX);
  localparam int COL_W = $clog2(GRID_W);
  localparam int ROW_W = $clog2(GRID_H);
  localparam int CNT_W = $clog2(1024 / CELL_PX + 1);

  localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(CELL_PX - 1);
  localparam logic [9:0]       V_VISIBLE   = 10'(GRID_H * CELL_PX);
  localparam logic [11:0]      GRID_COLOUR = 12'h222;

  // Incremental cell counters (replace px/CELL_PX and px%CELL_PX).
  logic [SUB_W-1:0] r_subX;
  logic [SUB_W-1:0] r_subY;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [SUB_W-1:0] w_subX;
  logic [SUB_W-1:0] w_subY;
  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_row;

  // Frame alignment.
  logic r_synced;
  logic w_synced;
  logic w_readNow;

  // Pipeline registers: stage 2 display flag and the sync delay line.
  logic r_de2;
  logic r_hs1;
  logic r_hs2;
  logic r_vs1;
  logic r_vs2;

  logic [11:0] w_pixColour;

  // Horizontal position within the row: restart at px == 0, otherwise step.
  always_comb begin
    w_subX = '0;
    w_col  = '0;
    if (px != '0) begin
      if (r_subX == SUB_LAST) begin
        w_subX = '0;
        w_col  = r_col + CNT_W'(1);
      end else begin
        w_subX = r_subX + SUB_W'(1);
        w_col  = r_col;
      end
    end
  end

  // Vertical position: only moves at the start of each line, restarts at py == 0.
  always_comb begin
    w_subY = r_subY;
    w_row  = r_row;
    if (px == '0) begin
      if (py == '0) begin
        w_subY = '0;
        w_row  = '0;
      end else if (r_subY == SUB_LAST) begin
        w_subY = '0;
        w_row  = r_row + CNT_W'(1);
      end else begin
        w_subY = r_subY + SUB_W'(1);
      end
    end
  end

  // The first top-left pixel counts as synced in the same cycle it is seen.
  always_comb begin
    w_synced  = r_synced | ((px == '0) && (py == '0));
    w_readNow = display_on & w_synced;
  end

  // Hold the counter state and the sticky synced flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_subX   <= '0;
      r_col    <= '0;
      r_subY   <= '0;
      r_row    <= '0;
      r_synced <= 1'b0;
    end else begin
      r_subX   <= w_subX;
      r_col    <= w_col;
      r_subY   <= w_subY;
      r_row    <= w_row;
      r_synced <= w_synced;
    end
  end

  // Stage 1: issue the RAM read; the address holds its last value in blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      rd_en      <= w_readNow;
      frame_tick <= w_synced && (px == '0) && (py == V_VISIBLE);
      if (w_readNow) begin
        rd_addr <= {w_row[ROW_W-1:0], w_col[COL_W-1:0]};
      end
    end
  end

  // Stages 1-2: carry the visible flag and syncs alongside the RAM access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de2 <= 1'b0;
      r_hs1 <= 1'b1;
      r_hs2 <= 1'b1;
      r_vs1 <= 1'b1;
      r_vs2 <= 1'b1;
    end else begin
      r_de2 <= rd_en;
      r_hs1 <= hsync_in;
      r_hs2 <= r_hs1;
      r_vs1 <= vsync_in;
      r_vs2 <= r_vs1;
    end
  end

`ifdef GRID_LINES_EN
  // Border flags travel two stages so they line up with the returned cell code.
  logic r_grid1;
  logic r_grid2;

  // Mark pixels on the first column or first row of a cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grid1 <= 1'b0;
      r_grid2 <= 1'b0;
    end else begin
      r_grid1 <= (w_subX == '0) || (w_subY == '0);
      r_grid2 <= r_grid1;
    end
  end
`endif

  // Map the cell code to its colour (empty cells get border lines if enabled).
  always_comb begin
    w_pixColour = COL_EMPTY;
    case (rd_data)
      2'b01:   w_pixColour = COL_BODY;
      2'b10:   w_pixColour = COL_HEAD;
      2'b11:   w_pixColour = COL_FOOD;
      default: w_pixColour = COL_EMPTY;
    endcase
`ifdef GRID_LINES_EN
    if ((rd_data == 2'b00) && r_grid2) begin
      w_pixColour = GRID_COLOUR;
    end
`endif
  end

  // Stage 3: register the pixel and the delayed syncs together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= r_de2 ? w_pixColour : 12'h000;
      hsync_out <= r_hs2;
      vsync_out <= r_vs2;
    end
  end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// tb_snake_pixel_renderer: drives VGA-style scan sequences (shortened lines,
// randomised line lengths and board contents) and compares every output each
// cycle with a reference model built from px/py arithmetic.
module tb_snake_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic        display_on = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  rd_addr;
  logic        rd_en;
  logic [1:0]  rd_data = '0;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_tick;

  typedef struct {
    bit valid;
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
    bit syn;
  } sample_t;

  sample_t  hist [3];
  sample_t  pending;
  bit [1:0] ram [0:1023];
  int       checkCount = 0;
  int       failCount = 0;
  int       tickSeen = 0;
  int       resetHold = 0;
  bit       modelSynced = 1'b0;
  int       modelAddr = 0;

  snake_pixel_renderer dut (
    .clk(clk),
    .rst_n(rst_n),
    .px(px),
    .py(py),
    .display_on(display_on),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .rd_addr(rd_addr),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rgb(rgb),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .frame_tick(frame_tick)
  );

  // 25 MHz pixel clock
  always #20 clk = ~clk;

  // synchronous board RAM: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  // expected pixel for a sample taken three cycles earlier
  function automatic int expColour(sample_t s);
    bit [1:0] code;
    int       colour;
    if (!s.valid || !s.de || !s.syn) return 0;
    code = ram[(s.y / 20) * 32 + (s.x / 20)];
    case (code)
      2'b00:   colour = 'h000;
      2'b01:   colour = 'h0F0;
      2'b10:   colour = 'hFF0;
      default: colour = 'hF00;
    endcase
`ifdef GRID_LINES_EN
    if (code == 2'b00 && ((s.x % 20) == 0 || (s.y % 20) == 0)) colour = 'h222;
`endif
    return colour;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      if (failCount <= 40)
        $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // advance the model by one sampled cycle and compare every output
  task automatic checkCycle();
    string where;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = pending;
    if (hist[0].valid && hist[0].de && hist[0].syn)
      modelAddr = (hist[0].y / 20) * 32 + (hist[0].x / 20);
    where = $sformatf("@(%0d,%0d)", hist[0].x, hist[0].y);
    checkOutput({"rd_en", where}, rd_en, (hist[0].valid && hist[0].de && hist[0].syn) ? 1 : 0);
    checkOutput({"rd_addr", where}, rd_addr, modelAddr);
    checkOutput({"frame_tick", where}, frame_tick,
                (hist[0].valid && hist[0].syn && hist[0].x == 0 && hist[0].y == 480) ? 1 : 0);
    where = $sformatf("@(%0d,%0d)", hist[2].x, hist[2].y);
    checkOutput({"rgb", where}, rgb, expColour(hist[2]));
    checkOutput({"hsync_out", where}, hsync_out, hist[2].valid ? hist[2].hs : 1'b1);
    checkOutput({"vsync_out", where}, vsync_out, hist[2].valid ? hist[2].vs : 1'b1);
    if (frame_tick === 1'b1) tickSeen++;
  endtask

  // one pixel clock: check the previous edge's results, then drive new inputs
  task automatic applyStimulus(int x, int y, bit de, bit hs, bit vs);
    @(negedge clk);
    checkCycle();
    if (resetHold > 0) begin
      resetHold--;
      if (resetHold == 0) rst_n = 1'b1;
    end
    px = 10'(x);
    py = 10'(y);
    display_on = de;
    hsync_in = hs;
    vsync_in = vs;
    if (rst_n && x == 0 && y == 0) modelSynced = 1'b1;
    pending.valid = rst_n;
    pending.x = x;
    pending.y = y;
    pending.de = de;
    pending.hs = hs;
    pending.vs = vs;
    pending.syn = rst_n && modelSynced;
  endtask

  // reset asserted between clock edges must clear outputs at once
  task automatic midReset();
    #5 rst_n = 1'b0;
    #1;
    checkOutput("async_rgb", rgb, 0);
    checkOutput("async_rd_en", rd_en, 0);
    checkOutput("async_rd_addr", rd_addr, 0);
    checkOutput("async_frame_tick", frame_tick, 0);
    checkOutput("async_hsync", hsync_out, 1);
    checkOutput("async_vsync", vsync_out, 1);
    pending.valid = 1'b0;
    for (int i = 0; i < 3; i++) hist[i].valid = 1'b0;
    modelSynced = 1'b0;
    modelAddr = 0;
    resetHold = 3;
  endtask

  // scan lines y0..y1; most lines are shortened, a few reach the columns of interest
  task automatic runLines(int y0, int y1, int xFirst);
    int width;
    bit hs;
    for (int y = y0; y <= y1; y++) begin
      if (y == 479) width = 800;
      else if (y == 5 || y == 25 || y == 63) width = 64;
      else width = 20 + int'($urandom_range(0, 7));
      for (int x = (y == y0) ? xFirst : 0; x < width; x++) begin
        if (width == 800) hs = !(x >= 656 && x < 752);
        else hs = !(x >= width - 3);
        applyStimulus(x, y, (x < 640 && y < 480), hs, !(y == 490 || y == 491));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 2'($urandom_range(0, 3));
    ram[98] = 2'b10;
    ram[2]  = 2'b00;
    ram[34] = 2'b01;
    ram[3]  = 2'b01;
    ram[4]  = 2'b11;
    for (int i = 0; i < 3; i++) hist[i].valid = 1'b0;
    pending.valid = 1'b0;
    rst_n = 1'b0;
    resetHold = 4;
    $display("[TB] reset released mid-line, then three synced frames");
    runLines(520, 524, 7);
    repeat (3) runLines(0, 524, 0);
    $display("[TB] asynchronous reset in the middle of a frame");
    runLines(0, 99, 0);
    for (int x = 0; x < 10; x++) applyStimulus(x, 100, 1'b1, 1'b1, 1'b1);
    midReset();
    runLines(100, 524, 10);
    runLines(0, 70, 0);
    checkOutput("tick_count", tickSeen, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
